// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, count widths/limits and tick divider helper.
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;
    localparam int MINS_W = 7;
    localparam int SECS_W = 6;
    localparam int DECS_W = 7;
    localparam logic [DECS_W-1:0] DECS_MAX = 7'd99;
    localparam logic [SECS_W-1:0] SECS_MAX = 6'd59;
    localparam logic [MINS_W-1:0] MINS_MAX = 7'd99;
    function automatic int tick_div(input int clk_freq_hz);
        return clk_freq_hz / 100;
    endfunction
endpackage

// File: rtl/stopwatch_prescaler.sv
// stopwatch_prescaler: divides the system clock to the 100 Hz hundredths tick.
module stopwatch_prescaler import stopwatch_pkg::*; #(
    parameter int TICK_DIV = 10
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = enable && cnt == W'(TICK_DIV - 1);
    // holds its phase while disabled so a resume keeps the partial hundredth
    always_ff @(posedge clock)
        if (!reset_n || clear) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: start/stop/clear FSM and mm:ss:hh counters of the stopwatch.
// Optional lap snapshot display is built when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_counter import stopwatch_pkg::*; #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_stop,
    input  logic              clear_lap,
    output logic [MINS_W-1:0] stopwatch_unit_mins,
    output logic [SECS_W-1:0] stopwatch_unit_secs,
    output logic [DECS_W-1:0] stopwatch_unit_decs,
    output logic              running,
    output logic              lap_active,
    output logic              rollover
);
    localparam int TICK_DIV = tick_div(CLK_FREQ_HZ);
    state_t state, state_next;
    logic ss_q, cl_q, ss_ev, cl_ev, tick;
    logic decs_wrap, secs_wrap, mins_wrap;
    logic [MINS_W-1:0] live_mins;
    logic [SECS_W-1:0] live_secs;
    logic [DECS_W-1:0] live_decs;
    // edges are registered so the FSM sees a button one edge after capture
    always_ff @(posedge clock)
        if (!reset_n) {ss_q, cl_q, ss_ev, cl_ev} <= '0;
        else begin
            ss_q  <= start_stop;
            cl_q  <= clear_lap;
            ss_ev <= start_stop & ~ss_q;
            cl_ev <= clear_lap & ~cl_q;
        end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (!cl_ev && ss_ev) ? RUNNING : IDLE;
            RUNNING: state_next = ss_ev ? PAUSED : RUNNING;
            PAUSED:  state_next = cl_ev ? IDLE : ss_ev ? RUNNING : PAUSED;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clock)
        state <= !reset_n ? IDLE : state_next;
    assign running = state == RUNNING;
    stopwatch_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (running),
        .clear   (state_next == IDLE),
        .tick    (tick)
    );
    assign decs_wrap = tick && live_decs == DECS_MAX;
    assign secs_wrap = decs_wrap && live_secs == SECS_MAX;
    assign mins_wrap = secs_wrap && live_mins == MINS_MAX;
    always_ff @(posedge clock)
        if (!reset_n || state_next == IDLE) begin
            live_decs <= '0;
            live_secs <= '0;
            live_mins <= '0;
            rollover  <= 1'b0;
        end else begin
            rollover <= mins_wrap;
            if (tick) live_decs <= decs_wrap ? '0 : live_decs + DECS_W'(1);
            if (decs_wrap) live_secs <= secs_wrap ? '0 : live_secs + SECS_W'(1);
            if (secs_wrap) live_mins <= mins_wrap ? '0 : live_mins + MINS_W'(1);
        end
`ifdef STOPWATCH_LAP_HOLD_EN
    logic lap_toggle;
    logic [MINS_W-1:0] snap_mins;
    logic [SECS_W-1:0] snap_secs;
    logic [DECS_W-1:0] snap_decs;
    assign lap_toggle = running && !ss_ev && cl_ev;
    always_ff @(posedge clock)
        if (!reset_n) begin
            lap_active <= 1'b0;
            {snap_mins, snap_secs, snap_decs} <= '0;
        end else if (state_next != RUNNING) lap_active <= 1'b0;
        else if (lap_toggle) begin
            lap_active <= !lap_active;
            if (!lap_active) {snap_mins, snap_secs, snap_decs} <= {live_mins, live_secs, live_decs};
        end
    assign stopwatch_unit_mins = lap_active ? snap_mins : live_mins;
    assign stopwatch_unit_secs = lap_active ? snap_secs : live_secs;
    assign stopwatch_unit_decs = lap_active ? snap_decs : live_decs;
`else
    assign lap_active = 1'b0;
    assign stopwatch_unit_mins = live_mins;
    assign stopwatch_unit_secs = live_secs;
    assign stopwatch_unit_decs = live_decs;
`endif
endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-base and counting core of the FPGA stopwatch. It divides the system clock to a 100 Hz tick and maintains a minutes:seconds:hundredths count under start/stop and clear/lap button control. The three count buses feed `SevenSegEncoder` directly (`stopwatch_unit_mins`, `stopwatch_unit_secs`, `stopwatch_unit_decs`).

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency. It must be a multiple of 100 and at least 200.
- `clock` input, 1 bit: system clock. All logic is on the rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset.
- `start_stop` input, 1 bit: debounced level from the button. Only the rising edge acts.
- `clear_lap` input, 1 bit: debounced level from the button. Only the rising edge acts.
- `stopwatch_unit_mins` output, 7 bits: minutes, 0–99.
- `stopwatch_unit_secs` output, 6 bits: seconds, 0–59.
- `stopwatch_unit_decs` output, 7 bits: hundredths, 0–99.
- `running` output, 1 bit: high in RUNNING.
- `lap_active` output, 1 bit: high while the display is frozen on a lap snapshot.
- `rollover` output, 1 bit: one-cycle pulse on the 99:59:99 → 00:00:00 wrap.

## Operation
- Input edge detection:
  - Each button is registered once into `*_q`.
  - An edge is `in & ~in_q`, evaluated on the registered path.
  - A button held high produces exactly one event.
- States are IDLE, RUNNING and PAUSED. Reset enters IDLE.
- Transitions:
  - IDLE, `start_stop` edge → RUNNING.
  - RUNNING, `start_stop` edge → PAUSED.
  - PAUSED, `start_stop` edge → RUNNING.
  - PAUSED, `clear_lap` edge → IDLE.
  - IDLE, `clear_lap` edge → stays IDLE, counts stay zero.
- Entering IDLE zeroes the counts and the prescaler.
- If both button edges occur in the same cycle:
  - In IDLE or PAUSED, the clear wins and `start_stop` is discarded.
  - In RUNNING, `start_stop` wins and `clear_lap` is discarded.
- Prescaler:
  - Counts 0 … TICK_DIV−1, where TICK_DIV = CLK_FREQ_HZ/100.
  - `tick` is high for one cycle when the prescaler is at TICK_DIV−1 in RUNNING.
  - The prescaler advances only in RUNNING and holds its value in PAUSED, so resume keeps the partial hundredth.
- Counting on `tick`:
  - `decs` increments. At 99 it wraps to 0 and carries into `secs`.
  - `secs` wraps 59 → 0 and carries into `mins`.
  - `mins` wraps 99 → 0, `rollover` pulses, and counting continues.
- Count values never exceed 99/59/99. Encodings 100–127 of `mins`/`decs` are unreachable.
- Reset in any state, including mid-count, returns every register to its reset value in the same edge.

## Timing
- Reset values: all count outputs 0, `running`=0, `lap_active`=0, `rollover`=0, prescaler 0, state IDLE.
- Button latency:
  - Button high at edge k is captured at k.
  - The state and `running` change at edge k+1.
- First tick after IDLE → RUNNING:
  - RUNNING is entered at edge e.
  - `decs` becomes 1 at edge e+TICK_DIV.
  - Subsequent increments come every TICK_DIV cycles.
- Counts update on the edge that closes a `tick` cycle. All outputs are registered, with no combinational path from the inputs.
- `rollover` is high for exactly the one cycle in which the counts read 00:00:00 after the wrap.

## Configuration
- `STOPWATCH_LAP_HOLD_EN` defined:
  - A `clear_lap` edge in RUNNING toggles `lap_active`.
  - Turning lap on copies the live count into snapshot registers, and the outputs show the snapshot. Counting continues internally.
  - Turning lap off shows the live count again from the next cycle.
  - Entering PAUSED or IDLE, or reset, clears `lap_active`.
- `STOPWATCH_LAP_HOLD_EN` undefined:
  - No snapshot registers are built.
  - `clear_lap` in RUNNING is ignored.
  - `lap_active` is tied to 0 and the outputs are always live.

## Structure
- Package `stopwatch_pkg` holds:
  - the state enum (IDLE/RUNNING/PAUSED);
  - the width constants 7/6/7;
  - the limits DECS_MAX=99, SECS_MAX=59, MINS_MAX=99;
  - the function computing TICK_DIV from CLK_FREQ_HZ.
- Sub-module `stopwatch_prescaler` takes `clock`, `reset_n`, `enable` and `clear`, has parameter TICK_DIV, and outputs `tick`.
- The state machine, edge detection, cascaded counters and lap snapshot live in the top level.

## Test plan
All scenarios use CLK_FREQ_HZ=1000, so TICK_DIV=10.
- Reset, then hold idle for 50 cycles → outputs 0/0/0, `running`=0, no `rollover`.
- `start_stop` pulse, then 10 cycles after entering RUNNING → `decs`=1. After 1000 cycles → 00:01:00, checked at the 99→0 carry.
- RUNNING at 00:00:37, pause for 200 cycles → count frozen at 37. Resume → first increment arrives after the held remainder of the prescaler, not a full TICK_DIV. Then `clear_lap` → IDLE with 0/0/0.
- Counts preloaded by running to 99:59:98, then two ticks → 99:59:99, then 00:00:00 with a one-cycle `rollover` and `running` still 1.
- Simultaneous edges:
  - Both edges in PAUSED → IDLE with counts 0.
  - Both edges in RUNNING → PAUSED with counts kept.
- With `STOPWATCH_LAP_HOLD_EN`: lap at 00:02:15 → outputs hold 00:02:15 for 300 cycles. Second `clear_lap` → outputs show 00:02:45. `reset_n` low mid-lap → all outputs 0 on the next edge.
